mac_pipe_nxn: RTL and testbench
===============================

Name: mac_pipe_nxn

Overview:
- Parametrised, pipelined multiply-accumulate unit.
- Takes DW x DW operands with per-operand signed/unsigned mode, same semantics as the existing 32x32 multiplier. Produces the full 2*DW product and a guarded running accumulator.
- Valid/ready handshake with whole-pipeline stall.
- Sits between operand sequencing logic and result consumers in the MAC datapath. Replaces the fixed-width, handshake-free multiplier where accumulation or backpressure is needed.

Parameters:
- DW, 32: operand width (>=4).
- LAT, 3: pipeline depth in stages, input accept to o_valid (>=1).
- GUARD, 8: accumulator guard bits. Derived: ACC_W = 2*DW + GUARD.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset. Asynchronous assert, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  unit can accept a beat this cycle.
- i_multa_ns  in  1  0: i_multa unsigned; 1: signed.
- i_multb_ns  in  1  0: i_multb unsigned; 1: signed.
- i_multa  in  DW  multiplicand.
- i_multb  in  DW  multiplier.
- i_acc_en  in  1  add this beat's product into the accumulator.
- i_acc_clr  in  1  clear the accumulator (and overflow flag) before applying this beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts output beat.
- o_product  out  2*DW  product of the output beat.
- o_acc  out  ACC_W  accumulator value after the output beat.
- o_acc_ovf  out  1  sticky signed overflow of the accumulator.

Behaviour:
- Reset: o_valid=0, o_product=0, o_acc=0, o_acc_ovf=0, all stage valids=0. o_ready=1 after reset.
- Accept: a beat is taken when i_valid && o_ready. Mode bits and acc controls travel with the beat.
- Stall:
  - stall = o_valid && !i_ready; o_ready = !stall.
  - During a stall every stage holds, including bubbles, and accumulator state is frozen.
  - No beat is lost or duplicated; order is preserved.
- Latency: LAT cycles from accept to o_valid with no stall. Throughput is 1 beat/cycle.
- Output hold: o_valid stays high and o_product/o_acc/o_acc_ovf stay stable until i_ready is sampled high. Bubbles propagate as o_valid=0.
- Product arithmetic:
  - Each operand is extended to DW+1 bits; the extension bit is ns & msb.
  - The product is the low 2*DW bits of the signed (DW+1)x(DW+1) product. This is exact for all four mode combinations.
  - Internal structure (Booth/tree split across stages) is free, provided stage count = LAT.
- Product extension to ACC_W:
  - Zero-extended when both ns=0.
  - Otherwise sign-extended from bit 2*DW-1.
- Accumulator update: occurs when a beat enters the final stage. Call the extended product P.
  - clr=1, en=1: acc=P, ovf=0.
  - clr=1, en=0: acc=0, ovf=0.
  - clr=0, en=1: acc=acc+P (wraps modulo 2^ACC_W). ovf |= signed overflow, i.e. operands share a sign and the result sign differs.
  - clr=0, en=0: acc and ovf unchanged.
- o_acc/o_acc_ovf reflect the state after the current output beat. Bubbles do not change the accumulator.
- Simultaneous events:
  - Accept and output transfer in the same cycle are both performed.
  - i_ready low while o_valid=0 causes no stall.
- Reset mid-operation: all in-flight beats are discarded and the accumulator is cleared immediately. No stale beat appears after release.
- Inputs other than i_valid are don't-care when not accepted.

Test Plan:
- Unsigned max: DW=32, a=b=0xFFFFFFFF, ns=00 -> after 3 cycles o_valid=1, o_product=0xFFFFFFFE00000001.
- Signed mixes:
  - a=0xFFFFFFFF, b=0xFFFFFFFF, ns=11 -> o_product=0x0000000000000001.
  - ns=10 (a signed) -> o_product=0xFFFFFFFF00000001.
- Accumulate: beat 3*4 with clr=1,en=1, then 5*6 with en=1, then 7*8 with clr=1,en=0 -> o_acc=12, 42, 0. o_acc_ovf=0 throughout.
- Backpressure: 6 back-to-back beats 1*1..6*6, i_ready low for 4 cycles once o_valid rises -> o_ready=0 during the stall. Outputs 1,4,9,16,25,36 appear in order, each exactly once, stable while held.
- Overflow: signed 0x80000000*0x80000000 (=2^62) accumulated repeatedly, GUARD=8 -> o_acc_ovf rises on beat 512 (o_acc wraps to -2^71) and stays high until a clr beat.
- Async reset: drop i_rstn with 3 beats in flight -> o_valid=0 and o_acc=0 immediately. After release, no output until a new beat arrives LAT cycles later.

Source files
------------

// File: rtl/mac_pipe_nxn_if.sv
// Handshake and data bundle for the pipelined MAC: operand beat in, product/accumulator beat out.
// slave is the MAC side, master is the operand sequencer / result consumer side.
interface mac_pipe_nxn_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned GUARD = 8
);
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACC_W = PW + GUARD;

    logic             i_valid;
    logic             o_ready;
    logic             i_multa_ns;
    logic             i_multb_ns;
    logic [DW-1:0]    i_multa;
    logic [DW-1:0]    i_multb;
    logic             i_acc_en;
    logic             i_acc_clr;
    logic             o_valid;
    logic             i_ready;
    logic [PW-1:0]    o_product;
    logic [ACC_W-1:0] o_acc;
    logic             o_acc_ovf;

    modport slave (
        input  i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb,
               i_acc_en, i_acc_clr, i_ready,
        output o_ready, o_valid, o_product, o_acc, o_acc_ovf
    );

    modport master (
        output i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb,
               i_acc_en, i_acc_clr, i_ready,
        input  o_ready, o_valid, o_product, o_acc, o_acc_ovf
    );
endinterface

// File: rtl/mac_pipe_nxn.sv
// Pipelined DW x DW multiply-accumulate with per-operand signedness, valid/ready
// handshake and a whole-pipeline stall. Accumulator lives in the output stage.
module mac_pipe_nxn #(
    parameter int unsigned DW    = 32,
    parameter int unsigned LAT   = 3,
    parameter int unsigned GUARD = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    mac_pipe_nxn_if.slave bus
);
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACC_W = PW + GUARD;

    typedef struct packed {
        logic          vld;
        logic          sx;
        logic          en;
        logic          clr;
        logic [PW-1:0] prod;
    } beat_t;

    logic             stall;
    logic             advance;
    logic [PW-1:0]    a_w;
    logic [PW-1:0]    b_w;
    beat_t            in_beat;
    beat_t            tail;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             sum_ovf;
    logic             ovf_nxt;

    // A held output beat freezes every stage, bubbles included.
    assign stall       = bus.o_valid && !bus.i_ready;
    assign advance     = !stall;
    assign bus.o_ready = advance;

    // Low 2*DW bits of the (DW+1)-bit signed product only depend on the
    // operands extended to 2*DW, so an unsigned 2*DW multiply is exact here.
    always_comb begin
        a_w          = {{DW{bus.i_multa_ns & bus.i_multa[DW-1]}}, bus.i_multa};
        b_w          = {{DW{bus.i_multb_ns & bus.i_multb[DW-1]}}, bus.i_multb};
        in_beat      = '0;
        in_beat.vld  = bus.i_valid;
        in_beat.sx   = bus.i_multa_ns | bus.i_multb_ns;
        in_beat.en   = bus.i_acc_en;
        in_beat.clr  = bus.i_acc_clr;
        in_beat.prod = a_w * b_w;
    end

    // LAT-1 delay stages ahead of the output/accumulator stage.
    generate
        if (LAT == 1) begin : g_direct
            assign tail = in_beat;
        end else if (LAT == 2) begin : g_one
            beat_t pipe_q;
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    pipe_q <= '0;
                end else if (advance) begin
                    pipe_q <= in_beat;
                end
            end
            assign tail = pipe_q;
        end else begin : g_multi
            beat_t [LAT-2:0] pipe_q;
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    pipe_q <= '0;
                end else if (advance) begin
                    pipe_q <= {pipe_q[LAT-3:0], in_beat};
                end
            end
            assign tail = pipe_q[LAT-2];
        end
    endgenerate

    // Next accumulator state for the beat entering the output stage.
    always_comb begin
        acc_nxt = bus.o_acc;
        ovf_nxt = bus.o_acc_ovf;
        p_ext   = tail.sx ? {{GUARD{tail.prod[PW-1]}}, tail.prod}
                          : {{GUARD{1'b0}}, tail.prod};
        acc_sum = bus.o_acc + p_ext;
        sum_ovf = (bus.o_acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                  (acc_sum[ACC_W-1] != bus.o_acc[ACC_W-1]);
        case ({tail.clr, tail.en})
            2'b11: begin
                acc_nxt = p_ext;
                ovf_nxt = 1'b0;
            end
            2'b10: begin
                acc_nxt = '0;
                ovf_nxt = 1'b0;
            end
            2'b01: begin
                acc_nxt = acc_sum;
                ovf_nxt = bus.o_acc_ovf | sum_ovf;
            end
            default: begin
                acc_nxt = bus.o_acc;
                ovf_nxt = bus.o_acc_ovf;
            end
        endcase
    end

    // Output stage; bubbles clear o_valid but leave data and accumulator untouched.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_valid   <= 1'b0;
            bus.o_product <= '0;
            bus.o_acc     <= '0;
            bus.o_acc_ovf <= 1'b0;
        end else if (advance) begin
            bus.o_valid <= tail.vld;
            if (tail.vld) begin
                bus.o_product <= tail.prod;
                bus.o_acc     <= acc_nxt;
                bus.o_acc_ovf <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe_nxn.sv
// Scoreboard bench for mac_pipe_nxn: directed plan cases plus randomized beats
// against an integer-arithmetic reference model.
module tb_mac_pipe_nxn;
    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 3;
    localparam int unsigned GUARD = 8;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACC_W = PW + GUARD;

    logic clk;
    logic rstn;

    mac_pipe_nxn_if #(.DW(DW), .GUARD(GUARD)) bus ();

    mac_pipe_nxn #(.DW(DW), .LAT(LAT), .GUARD(GUARD)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [PW-1:0]    prod;
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    exp_t             expq[$];
    logic [PW-1:0]    obs_prod[$];
    logic [ACC_W-1:0] obs_acc[$];
    logic             obs_ovf[$];

    logic signed [127:0] m_acc;
    logic                m_ovf;
    int checks   = 0;
    int errors   = 0;
    int rdy_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference: operands as integers, exact product, accumulator kept in
    // [-2^71, 2^71) and wrapped by 2^72 whenever the true sum leaves that range.
    function automatic void model_push(input logic [31:0] a, input logic [31:0] b,
                                       input logic nsa, input logic nsb,
                                       input logic en, input logic clr);
        logic signed [127:0] va, vb, pv, lim;
        logic [127:0] full;
        logic [63:0]  prod;
        exp_t e;
        lim = 128'sd1 <<< 71;
        va = {96'd0, a};
        if (nsa && a[31]) va = va - (128'sd1 <<< 32);
        vb = {96'd0, b};
        if (nsb && b[31]) vb = vb - (128'sd1 <<< 32);
        full = va * vb;
        prod = full[63:0];
        pv = {64'd0, prod};
        if ((nsa || nsb) && prod[63]) pv = pv - (128'sd1 <<< 64);
        if (clr) begin
            m_acc = '0;
            m_ovf = 1'b0;
        end
        if (en) begin
            m_acc = m_acc + pv;
            if (m_acc >= lim) begin
                m_acc = m_acc - (lim <<< 1);
                m_ovf = 1'b1;
            end else if (m_acc < -lim) begin
                m_acc = m_acc + (lim <<< 1);
                m_ovf = 1'b1;
            end
        end
        e.prod = prod;
        e.acc  = m_acc[71:0];
        e.ovf  = m_ovf;
        expq.push_back(e);
    endfunction

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ($urandom_range(0, 3) != 0);
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every visible output beat must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && bus.o_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got product 0x%0h with o_valid=1, expected no output", bus.o_product);
                end else begin
                    exp_t e;
                    e = expq[0];
                    chk("product", 128'(bus.o_product), 128'(e.prod));
                    chk("acc", 128'(bus.o_acc), 128'(e.acc));
                    chk("acc_ovf", 128'(bus.o_acc_ovf), 128'(e.ovf));
                    if (bus.i_ready === 1'b1) begin
                        void'(expq.pop_front());
                        obs_prod.push_back(bus.o_product);
                        obs_acc.push_back(bus.o_acc);
                        obs_ovf.push_back(bus.o_acc_ovf);
                    end
                end
            end
        end
    end

    task automatic clear_obs();
        obs_prod.delete();
        obs_acc.delete();
        obs_ovf.delete();
    endtask

    // Present one beat (called #1 after a rising edge) and hold it until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic nsa,
                        input logic nsb, input logic en, input logic clr);
        bit done;
        bit ok;
        done = 1'b0;
        bus.i_valid    = 1'b1;
        bus.i_multa    = a;
        bus.i_multb    = b;
        bus.i_multa_ns = nsa;
        bus.i_multb_ns = nsb;
        bus.i_acc_en   = en;
        bus.i_acc_clr  = clr;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            ok = bus.o_ready;
            @(posedge clk);
            if (ok) begin
                done = 1'b1;
                model_push(a, b, nsa, nsb, en, clr);
            end
            #1;
        end
        bus.i_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept in 200 cycles, expected o_ready");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 1000 && expq.size() != 0; t++) @(posedge clk);
        chk("drain", 128'(expq.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // One beat on an idle pipe: measure latency and check product against a constant.
    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic nsa,
                          input logic nsb, input logic [63:0] kprod, input string name);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        chk({name, "_ready"}, 128'(bus.o_ready), 128'(1));
        bus.i_valid    = 1'b1;
        bus.i_multa    = a;
        bus.i_multb    = b;
        bus.i_multa_ns = nsa;
        bus.i_multb_ns = nsb;
        bus.i_acc_en   = 1'b1;
        bus.i_acc_clr  = 1'b1;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk);
            if (t == 0) begin
                model_push(a, b, nsa, nsb, 1'b1, 1'b1);
                #1;
                bus.i_valid = 1'b0;
            end
            lat++;
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                seen = 1'b1;
                chk(name, 128'(bus.o_product), 128'(kprod));
            end
        end
        chk({name, "_latency"}, 128'(lat), 128'(LAT));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rstn           = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_multa    = '0;
        bus.i_multb    = '0;
        bus.i_multa_ns = 1'b0;
        bus.i_multb_ns = 1'b0;
        bus.i_acc_en   = 1'b0;
        bus.i_acc_clr  = 1'b0;
        m_acc          = '0;
        m_ovf          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_o_valid", 128'(bus.o_valid), 128'(0));
        chk("rst_o_product", 128'(bus.o_product), 128'(0));
        chk("rst_o_acc", 128'(bus.o_acc), 128'(0));
        chk("rst_o_acc_ovf", 128'(bus.o_acc_ovf), 128'(0));
        chk("rst_o_ready", 128'(bus.o_ready), 128'(1));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, "smax");
        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, "mixed");

        // Accumulate: load, add, clear-without-add.
        clear_obs();
        send(32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        send(32'd5, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        send(32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("acc_count", 128'(obs_acc.size()), 128'(3));
        chk("acc_0", 128'(obs_acc[0]), 128'(12));
        chk("acc_1", 128'(obs_acc[1]), 128'(42));
        chk("acc_2", 128'(obs_acc[2]), 128'(0));
        for (int i = 0; i < 3; i++) chk("acc_ovf_low", 128'(obs_ovf[i]), 128'(0));

        // Backpressure: 4-cycle stall as soon as the first result shows up.
        clear_obs();
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(32'(i), 32'(i), 1'b0, 1'b0, 1'b1, (i == 1));
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    if (bus.o_valid === 1'b1) seen = 1'b1;
                end
                chk("bp_first_out", 128'(seen), 128'(1));
                rdy_mode = 2;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_o_ready_low", 128'(bus.o_ready), 128'(0));
                end
                rdy_mode = 0;
            end
        join
        drain();
        chk("bp_count", 128'(obs_prod.size()), 128'(6));
        for (int i = 0; i < 6; i++)
            chk("bp_order", 128'(obs_prod[i]), 128'((i + 1) * (i + 1)));

        // Signed overflow: 2^62 added until the 72-bit accumulator wraps.
        clear_obs();
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 512; i++)
            send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        send(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("ovf_count", 128'(obs_acc.size()), 128'(514));
        chk("ovf_before", 128'(obs_ovf[510]), 128'(0));
        chk("ovf_acc_before", 128'(obs_acc[510]), 128'(72'h7F_C000_0000_0000_0000));
        chk("ovf_rise", 128'(obs_ovf[511]), 128'(1));
        chk("ovf_wrap_acc", 128'(obs_acc[511]), 128'(72'h80_0000_0000_0000_0000));
        chk("ovf_sticky", 128'(obs_ovf[512]), 128'(1));
        chk("ovf_cleared", 128'(obs_ovf[513]), 128'(0));
        chk("ovf_clr_acc", 128'(obs_acc[513]), 128'(0));

        // Asynchronous reset with beats in flight.
        send(32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) send(32'd4, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        expq.delete();
        m_acc = '0;
        m_ovf = 1'b0;
        #1;
        chk("arst_o_valid", 128'(bus.o_valid), 128'(0));
        chk("arst_o_acc", 128'(bus.o_acc), 128'(0));
        chk("arst_o_acc_ovf", 128'(bus.o_acc_ovf), 128'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("arst_no_stale", 128'(bus.o_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        single(32'd9, 32'd7, 1'b0, 1'b0, 64'd63, "post_rst");

        // Randomized beats with random gaps and random backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, b;
            int sel;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            sel = $urandom_range(0, 7);
            a = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h8000_0000 : (sel == 2) ? 32'd0 : $urandom;
            sel = $urandom_range(0, 7);
            b = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h8000_0000 : (sel == 2) ? 32'd0 : $urandom;
            send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0));
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        chk("queue_empty", 128'(expq.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
